// File: rtl/debug_link_pkg.sv
// rtl/debug_link_pkg.sv - shared constants and receiver state type for the debug serial link
package debug_link_pkg;
  localparam int DEBUG_WORD_W    = 40;
  localparam int DEBUG_ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DROP  = 2'd2
  } rx_state_t;
endpackage

// File: rtl/debug_rx_hold.sv
// rtl/debug_rx_hold.sv - one-entry valid/ready holding register with sticky overflow flag
module debug_rx_hold
  import debug_link_pkg::*;
#(
  parameter int WIDTH = DEBUG_WORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_commit,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_ovf
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (i_commit) begin
      // A consumer taking the old word on the commit edge frees the slot.
      if (!r_valid || i_ready) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else begin
        r_ovf <= 1'b1;
      end
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/debug_data_receiver.sv
// rtl/debug_data_receiver.sv - LSB-first 40-bit frame deserializer with length checking
// Optional saturating error counter enabled by DEBUG_RX_ERR_CNT_EN.
module debug_data_receiver
  import debug_link_pkg::*;
#(
  parameter int WIDTH = DEBUG_WORD_W,
  parameter int CNT_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sin,
  input  logic                       sin_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       err_short,
  output logic                       err_long,
  output logic                       err_ovf,
  output logic [DEBUG_ERR_CNT_W-1:0] err_count
);

  rx_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_err_short;
  logic             r_err_long;

  logic w_full;
  logic w_commit;
  logic w_short_det;
  logic w_long_det;

  assign w_full      = (r_cnt == CNT_W'(WIDTH));
  assign w_commit    = (r_state == SHIFT) && !sin_valid && w_full;
  assign w_short_det = (r_state == SHIFT) && !sin_valid && !w_full;
  assign w_long_det  = (r_state == SHIFT) && sin_valid && w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_err_short <= w_short_det;
      r_err_long  <= w_long_det;
      if (sin_valid) r_shreg <= {sin, r_shreg[WIDTH-1:1]};
      case (r_state)
        IDLE: begin
          if (sin_valid) begin
            r_cnt   <= CNT_W'(1);
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sin_valid && !w_full) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt   <= '0;
            r_state <= sin_valid ? DROP : IDLE;
          end
        end
        DROP: begin
          if (!sin_valid) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  debug_rx_hold #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_commit (w_commit),
    .i_data   (r_shreg),
    .i_ready  (out_ready),
    .o_data   (out_data),
    .o_valid  (out_valid),
    .o_ovf    (err_ovf)
  );

  assign err_short = r_err_short;
  assign err_long  = r_err_long;

`ifdef DEBUG_RX_ERR_CNT_EN
  logic [DEBUG_ERR_CNT_W-1:0] r_err_count;
  logic                       w_err_evt;

  // Short, long and overflow events are mutually exclusive on any edge.
  assign w_err_evt = w_short_det || w_long_det || (w_commit && out_valid && !out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_err_evt && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_debug_data_receiver.sv
// tb/tb_debug_data_receiver.sv - directed self-checking bench for debug_data_receiver
module tb_debug_data_receiver;

  logic        clk;
  logic        rst_n;
  logic        sin;
  logic        sin_valid;
  logic [39:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err_short;
  logic        err_long;
  logic        err_ovf;
  logic [7:0]  err_count;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef DEBUG_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [39:0] W_A = 40'hA999999991;
  localparam logic [39:0] W_B = 40'hE999999993;
  localparam logic [39:0] W_C = 40'h123456789A;
  localparam logic [39:0] W_D = 40'h00FFFF0001;
  localparam logic [39:0] W_E = 40'h5A5A5A5A5A;
  localparam logic [39:0] W_F = 40'hC3C3C3C3C3;
  localparam logic [39:0] W_G = 40'h0F0F0F0F0F;
  localparam logic [39:0] W_H = 40'h8000000001;

  debug_data_receiver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_valid (sin_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_short (err_short),
    .err_long  (err_long),
    .err_ovf   (err_ovf),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic b);
    @(negedge clk);
    sin_valid = v;
    sin       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [39:0] w, input int n);
    for (int i = 0; i < n; i++) step(1'b1, w[i % 40]);
  endtask

  function automatic logic [39:0] ecnt(input int n);
    return CNT_EN ? 40'(n) : 40'd0;
  endfunction

  initial begin
    logic [39:0] w_h;
    w_h       = W_H;
    rst_n     = 1'b0;
    sin       = 1'b0;
    sin_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data",  out_data,  40'd0);
    check("rst_out_valid", 40'(out_valid), 40'd0);
    check("rst_err_short", 40'(err_short), 40'd0);
    check("rst_err_long",  40'(err_long),  40'd0);
    check("rst_err_ovf",   40'(err_ovf),   40'd0);
    check("rst_err_count", 40'(err_count), 40'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single frame: commit on edge 41, consumed on edge 42
    send(W_A, 40);
    step(1'b0, 1'b0);
    check("single_valid", 40'(out_valid), 40'd1);
    check("single_data",  out_data, W_A);
    step(1'b0, 1'b0);
    check("single_consumed", 40'(out_valid), 40'd0);
    check("single_data_hold", out_data, W_A);

    // back-to-back frames with a single low cycle
    send(W_A, 40);
    step(1'b0, 1'b0);
    check("b2b_first", out_data, W_A);
    send(W_B, 40);
    step(1'b0, 1'b0);
    check("b2b_second", out_data, W_B);
    check("b2b_valid",  40'(out_valid), 40'd1);
    check("b2b_no_short", 40'(err_short), 40'd0);
    check("b2b_count", 40'(err_count), 40'd0);
    step(1'b0, 1'b0);

    // short frame of 17 samples
    send(W_C, 17);
    step(1'b0, 1'b0);
    check("short_pulse", 40'(err_short), 40'd1);
    check("short_no_commit", 40'(out_valid), 40'd0);
    check("short_count", 40'(err_count), ecnt(1));
    step(1'b0, 1'b0);
    check("short_pulse_end", 40'(err_short), 40'd0);
    send(W_C, 40);
    step(1'b0, 1'b0);
    check("short_next_data", out_data, W_C);
    check("short_next_valid", 40'(out_valid), 40'd1);

    // long frame of 45 samples: detected on sample 41
    send(W_D, 40);
    check("long_not_yet", 40'(err_long), 40'd0);
    send(W_D, 1);
    check("long_pulse", 40'(err_long), 40'd1);
    check("long_count", 40'(err_count), ecnt(2));
    send(W_D, 1);
    check("long_pulse_end", 40'(err_long), 40'd0);
    send(W_D, 3);
    step(1'b0, 1'b0);
    check("long_no_commit", 40'(out_valid), 40'd0);
    send(W_D, 40);
    step(1'b0, 1'b0);
    check("long_next_data", out_data, W_D);
    step(1'b0, 1'b0);

    // overflow with consumer stalled
    out_ready = 1'b0;
    send(W_E, 40);
    step(1'b0, 1'b0);
    check("ovf_first_data", out_data, W_E);
    check("ovf_flag_clear", 40'(err_ovf), 40'd0);
    send(W_F, 40);
    step(1'b0, 1'b0);
    check("ovf_data_kept", out_data, W_E);
    check("ovf_valid_kept", 40'(out_valid), 40'd1);
    check("ovf_flag_set", 40'(err_ovf), 40'd1);
    check("ovf_count", 40'(err_count), ecnt(3));
    send(W_G, 40);
    out_ready = 1'b1;
    step(1'b0, 1'b0);
    out_ready = 1'b0;
    check("ovf_replace_data", out_data, W_G);
    check("ovf_replace_valid", 40'(out_valid), 40'd1);
    check("ovf_flag_sticky", 40'(err_ovf), 40'd1);
    check("ovf_replace_count", 40'(err_count), ecnt(3));

    // reset asserted at sample 20 of a frame
    send(W_H, 19);
    @(negedge clk);
    rst_n     = 1'b0;
    sin_valid = 1'b1;
    sin       = w_h[19];
    #1;
    check("mrst_out_data",  out_data, 40'd0);
    check("mrst_out_valid", 40'(out_valid), 40'd0);
    check("mrst_err_short", 40'(err_short), 40'd0);
    check("mrst_err_long",  40'(err_long),  40'd0);
    check("mrst_err_ovf",   40'(err_ovf),   40'd0);
    check("mrst_err_count", 40'(err_count), 40'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 20; i < 40; i++) step(1'b1, w_h[i]);
    step(1'b0, 1'b0);
    check("mrst_tail_short", 40'(err_short), 40'd1);
    check("mrst_tail_no_commit", 40'(out_valid), 40'd0);
    check("mrst_tail_count", 40'(err_count), ecnt(1));
    send(W_H, 40);
    step(1'b0, 1'b0);
    check("mrst_next_data", out_data, W_H);
    check("mrst_next_valid", 40'(out_valid), 40'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
